// File: rtl/temp_read_scheduler.sv
// temp_read_scheduler: sequences the sensor config write and two-byte temperature reads over an I2C transaction engine
module temp_read_scheduler #(
  parameter logic [6:0] DEV_ADDR    = 7'h4B,
  parameter logic [7:0] CFG_REG     = 8'h03,
  parameter logic [7:0] CFG_VALUE   = 8'h80,
  parameter int         PERIOD_CYC  = 10000000,
  parameter int         TIMEOUT_CYC = 200000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_control,
  output logic        txn_start,
  output logic        txn_rw,
  output logic [6:0]  txn_dev_addr,
  output logic [7:0]  txn_reg_addr,
  output logic [7:0]  txn_wdata,
  input  logic        txn_busy,
  input  logic        txn_done,
  input  logic        txn_ack_err,
  input  logic [7:0]  txn_rdata,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        err_sticky,
  output logic [15:0] read_count,
  output logic [7:0]  State
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, CFG_ISSUE = 4'd1, CFG_WAIT = 4'd2, MSB_ISSUE = 4'd3, MSB_WAIT = 4'd4,
    LSB_ISSUE = 4'd5, LSB_WAIT = 4'd6, UPDATE = 4'd7, FAIL = 4'd8
  } state_t;
  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry;
  logic [2:0]    pc_prev;
  logic [2:0]    pc_cur;
  logic [7:0]    msb;
  logic          read_pending, cfg_pending, rd_again, fail_cfg;
  logic          rd_edge, cfg_edge, clr_edge, period_hit, rd_trig, in_read;
  logic          done_ok, fail_now, retry_ok;
  logic          unused_pc;
  assign unused_pc  = ^PC_control[31:4];
  assign pc_cur     = {PC_control[3], PC_control[2], PC_control[0]};
  assign rd_edge    = pc_cur[0] & ~pc_prev[0];
  assign cfg_edge   = pc_cur[1] & ~pc_prev[1];
  assign clr_edge   = pc_cur[2] & ~pc_prev[2];
  assign period_hit = PC_control[1] && period_cnt == PW'(PERIOD_CYC - 1);
  assign rd_trig    = rd_edge | period_hit;
  assign in_read    = state inside {MSB_ISSUE, MSB_WAIT, LSB_ISSUE, LSB_WAIT};
  assign done_ok    = txn_done && !txn_ack_err;
  assign fail_now   = (txn_done && txn_ack_err) || (!txn_done && tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign retry_ok   = retry + 1'b1 < RW'(MAX_RETRY);
  assign State      = {4'h0, state};
  // a request seen while a read is in flight is remembered in rd_again so it survives the UPDATE/FAIL clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      txn_start    <= 1'b0;
      txn_rw       <= 1'b0;
      txn_dev_addr <= '0;
      txn_reg_addr <= '0;
      txn_wdata    <= '0;
      temp_data    <= '0;
      temp_valid   <= 1'b0;
      err_sticky   <= 1'b0;
      read_count   <= '0;
      period_cnt   <= '0;
      tmo_cnt      <= '0;
      retry        <= '0;
      pc_prev      <= '0;
      msb          <= '0;
      read_pending <= 1'b0;
      cfg_pending  <= 1'b1;
      rd_again     <= 1'b0;
      fail_cfg     <= 1'b0;
    end else begin
      pc_prev    <= pc_cur;
      txn_start  <= 1'b0;
      temp_valid <= 1'b0;
      period_cnt <= (!PC_control[1] || period_hit) ? '0 : period_cnt + 1'b1;
      if (cfg_edge) cfg_pending <= 1'b1;
      if (rd_trig) read_pending <= 1'b1;
      if (rd_trig && in_read) rd_again <= 1'b1;
      if (clr_edge) err_sticky <= 1'b0;
      case (state)
        IDLE: state <= cfg_pending ? CFG_ISSUE : read_pending ? MSB_ISSUE : IDLE;
        CFG_ISSUE, MSB_ISSUE, LSB_ISSUE: if (!txn_busy) begin
          txn_start    <= 1'b1;
          txn_rw       <= state != CFG_ISSUE;
          txn_dev_addr <= DEV_ADDR;
          txn_reg_addr <= state == CFG_ISSUE ? CFG_REG : state == MSB_ISSUE ? 8'h00 : 8'h01;
          if (state == CFG_ISSUE) txn_wdata <= CFG_VALUE;
          tmo_cnt      <= '0;
          state        <= state == CFG_ISSUE ? CFG_WAIT : state == MSB_ISSUE ? MSB_WAIT : LSB_WAIT;
        end
        CFG_WAIT, MSB_WAIT, LSB_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (done_ok) begin
            if (state == CFG_WAIT) begin
              cfg_pending <= cfg_edge;
              retry       <= '0;
              state       <= IDLE;
            end else if (state == MSB_WAIT) begin
              msb   <= txn_rdata;
              state <= LSB_ISSUE;
            end else begin
              temp_data  <= {msb, txn_rdata};
              temp_valid <= 1'b1;
              read_count <= read_count + 1'b1;
              state      <= UPDATE;
            end
          end else if (fail_now) begin
            retry    <= retry + 1'b1;
            fail_cfg <= state == CFG_WAIT;
            state    <= !retry_ok ? FAIL : state == CFG_WAIT ? CFG_ISSUE : MSB_ISSUE;
          end
        end
        UPDATE: begin
          retry        <= '0;
          read_pending <= rd_again | rd_trig;
          rd_again     <= 1'b0;
          state        <= IDLE;
        end
        FAIL: begin
          err_sticky <= 1'b1;
          retry      <= '0;
          if (fail_cfg) cfg_pending <= cfg_edge;
          else begin
            read_pending <= rd_again | rd_trig;
            rd_again     <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_temp_read_scheduler.sv
// tb_temp_read_scheduler: directed tests of the scheduler against a 20-cycle I2C engine model
module tb_temp_read_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC_control = '0;
  logic        txn_start, txn_rw;
  logic [6:0]  txn_dev_addr;
  logic [7:0]  txn_reg_addr, txn_wdata;
  logic        txn_busy, txn_done, txn_ack_err;
  logic [7:0]  txn_rdata;
  logic [15:0] temp_data, read_count;
  logic        temp_valid, err_sticky;
  logic [7:0]  State;
  int          tests = 0, fails = 0;
  logic [7:0]  msb_val = 8'h00, lsb_val = 8'h00;
  int          nack_total = 0, nacks_done = 0;
  logic        hang = 1'b0;
  int          eng_cnt;
  logic [7:0]  cur_reg;
  int          n_cfg = 0, n_msb = 0, n_lsb = 0, n_valid = 0;
  logic        last_rw;
  logic [6:0]  last_dev;
  logic [7:0]  last_reg, last_wdata;

  temp_read_scheduler #(.PERIOD_CYC(1000), .TIMEOUT_CYC(50), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .PC_control(PC_control),
    .txn_start(txn_start), .txn_rw(txn_rw), .txn_dev_addr(txn_dev_addr),
    .txn_reg_addr(txn_reg_addr), .txn_wdata(txn_wdata), .txn_busy(txn_busy),
    .txn_done(txn_done), .txn_ack_err(txn_ack_err), .txn_rdata(txn_rdata),
    .temp_data(temp_data), .temp_valid(temp_valid), .err_sticky(err_sticky),
    .read_count(read_count), .State(State)
  );

  always #5 clk = ~clk;

  // engine model: done 20 cycles after start, data chosen by register, optional LSB NACKs or no response
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_busy <= 1'b0; txn_done <= 1'b0; txn_ack_err <= 1'b0; txn_rdata <= '0; eng_cnt <= 0; cur_reg <= '0;
    end else begin
      txn_done <= 1'b0;
      if (txn_start && !hang) begin
        txn_busy <= 1'b1; eng_cnt <= 1; cur_reg <= txn_reg_addr;
      end else if (txn_busy) begin
        if (eng_cnt == 20) begin
          txn_busy    <= 1'b0;
          txn_done    <= 1'b1;
          txn_ack_err <= cur_reg == 8'h01 && nacks_done < nack_total;
          if (cur_reg == 8'h01 && nacks_done < nack_total) nacks_done <= nacks_done + 1;
          txn_rdata   <= cur_reg == 8'h00 ? msb_val : lsb_val;
        end else eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (txn_start) begin
      last_rw <= txn_rw; last_dev <= txn_dev_addr; last_reg <= txn_reg_addr; last_wdata <= txn_wdata;
      if (txn_reg_addr == 8'h03) n_cfg <= n_cfg + 1;
      if (txn_reg_addr == 8'h00) n_msb <= n_msb + 1;
      if (txn_reg_addr == 8'h01) n_lsb <= n_lsb + 1;
    end
    if (temp_valid) n_valid <= n_valid + 1;
  end

  task automatic pulse_read();
    @(negedge clk) PC_control = 32'h1;
    @(negedge clk) PC_control = 32'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (State !== 8'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", State); end
    tests++; if ({txn_start, txn_rw, txn_dev_addr, txn_reg_addr, txn_wdata} !== 25'd0) begin fails++; $display("FAIL reset_txn: got %b %b %h %h %h want all 0", txn_start, txn_rw, txn_dev_addr, txn_reg_addr, txn_wdata); end
    tests++; if ({temp_data, temp_valid, err_sticky, read_count} !== 34'd0) begin fails++; $display("FAIL reset_outputs: got %h %b %b %h want all 0", temp_data, temp_valid, err_sticky, read_count); end
    reset = 1'b0;
  endtask

  task automatic test_config();
    for (int i = 0; i < 10 && n_cfg == 0; i++) @(negedge clk);
    tests++; if (n_cfg !== 1) begin fails++; $display("FAIL cfg_issued: got %0d cfg writes want 1", n_cfg); end
    tests++; if ({last_rw, last_dev, last_reg, last_wdata} !== {1'b0, 7'h4B, 8'h03, 8'h80}) begin fails++; $display("FAIL cfg_fields: got rw=%b dev=%h reg=%h wdata=%h want 0 4b 03 80", last_rw, last_dev, last_reg, last_wdata); end
    repeat (60) @(negedge clk);
    tests++; if (State !== 8'd0) begin fails++; $display("FAIL cfg_idle: got state %0d want 0", State); end
    tests++; if (n_msb !== 0) begin fails++; $display("FAIL cfg_no_read: got %0d reads want 0", n_msb); end
  endtask

  task automatic test_single_read();
    msb_val = 8'h0C; lsb_val = 8'h80;
    @(negedge clk) PC_control = 32'h1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    tests++; if ({txn_start, txn_rw, txn_reg_addr} !== {1'b1, 1'b1, 8'h00}) begin fails++; $display("FAIL read_latency: got start=%b rw=%b reg=%h want 1 1 00", txn_start, txn_rw, txn_reg_addr); end
    @(negedge clk) PC_control = 32'h0;
    for (int i = 0; i < 200 && !temp_valid; i++) @(negedge clk);
    tests++; if (temp_valid !== 1'b1) begin fails++; $display("FAIL read_valid: got %b want 1 within 200 cycles", temp_valid); end
    tests++; if (temp_data !== 16'h0C80) begin fails++; $display("FAIL read_data: got %h want 0c80", temp_data); end
    tests++; if (read_count !== 16'd1) begin fails++; $display("FAIL read_count1: got %0d want 1", read_count); end
    @(negedge clk);
    tests++; if (temp_valid !== 1'b0) begin fails++; $display("FAIL read_pulse: got %b want 0 one cycle later", temp_valid); end
    tests++; if ({n_msb, n_lsb, n_valid} !== {32'd1, 32'd1, 32'd1}) begin fails++; $display("FAIL read_order: got msb=%0d lsb=%0d valid=%0d want 1 1 1", n_msb, n_lsb, n_valid); end
  endtask

  task automatic test_periodic();
    int v0;
    v0 = n_valid; msb_val = 8'h12; lsb_val = 8'h34;
    @(negedge clk) PC_control = 32'h2;
    repeat (3500) @(negedge clk);
    PC_control = 32'h0;
    repeat (100) @(negedge clk);
    tests++; if (n_valid - v0 !== 3) begin fails++; $display("FAIL periodic_reads: got %0d want 3", n_valid - v0); end
    tests++; if (read_count !== 16'd4) begin fails++; $display("FAIL periodic_count: got %0d want 4", read_count); end
    tests++; if (temp_data !== 16'h1234) begin fails++; $display("FAIL periodic_data: got %h want 1234", temp_data); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    @(negedge clk) PC_control = 32'h1;
    for (int i = 0; i < 20 && State != 8'd4; i++) @(negedge clk);
    tests++; if (State !== 8'd4) begin fails++; $display("FAIL b2b_msb_wait: got state %0d want 4", State); end
    repeat (2) begin
      @(negedge clk) PC_control = 32'h0;
      @(negedge clk) PC_control = 32'h1;
    end
    @(negedge clk) PC_control = 32'h0;
    repeat (200) @(negedge clk);
    tests++; if (n_valid - v0 !== 2) begin fails++; $display("FAIL b2b_coalesce: got %0d reads want 2", n_valid - v0); end
    tests++; if (read_count !== 16'd6) begin fails++; $display("FAIL b2b_count: got %0d want 6", read_count); end
  endtask

  task automatic test_nack_retry();
    int v0, m0, l0;
    v0 = n_valid; m0 = n_msb; l0 = n_lsb;
    msb_val = 8'h1A; lsb_val = 8'h2B; nack_total = 1;
    pulse_read();
    repeat (300) @(negedge clk);
    tests++; if ({n_msb - m0, n_lsb - l0} !== {32'd2, 32'd2}) begin fails++; $display("FAIL nack_rereads: got msb=%0d lsb=%0d want 2 2", n_msb - m0, n_lsb - l0); end
    tests++; if (temp_data !== 16'h1A2B) begin fails++; $display("FAIL nack_data: got %h want 1a2b", temp_data); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL nack_err: got %b want 0", err_sticky); end
    tests++; if (n_valid - v0 !== 1 || read_count !== 16'd7) begin fails++; $display("FAIL nack_count: got valid=%0d count=%0d want 1 7", n_valid - v0, read_count); end
  endtask

  task automatic test_timeout();
    int m0;
    m0 = n_msb; hang = 1'b1;
    pulse_read();
    for (int i = 0; i < 300 && !err_sticky; i++) @(negedge clk);
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1 within 300 cycles", err_sticky); end
    repeat (60) @(negedge clk);
    tests++; if (n_msb - m0 !== 2) begin fails++; $display("FAIL tmo_attempts: got %0d want 2", n_msb - m0); end
    tests++; if (temp_data !== 16'h1A2B || read_count !== 16'd7) begin fails++; $display("FAIL tmo_retain: got %h %0d want 1a2b 7", temp_data, read_count); end
    tests++; if (State !== 8'd0) begin fails++; $display("FAIL tmo_idle: got state %0d want 0", State); end
    @(negedge clk) PC_control = 32'h8;
    @(negedge clk) PC_control = 32'h0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b want 0", err_sticky); end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0, v0;
    c0 = n_cfg; v0 = n_valid;
    @(negedge clk) PC_control = 32'h1;
    for (int i = 0; i < 20 && State != 8'd4; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1; #1;
    tests++; if ({State, txn_start, temp_valid, err_sticky} !== 11'd0) begin fails++; $display("FAIL rst_mid_ctrl: got state=%0d start=%b valid=%b err=%b want 0", State, txn_start, temp_valid, err_sticky); end
    tests++; if ({temp_data, read_count, txn_reg_addr} !== 40'd0) begin fails++; $display("FAIL rst_mid_data: got %h %h %h want 0", temp_data, read_count, txn_reg_addr); end
    PC_control = 32'h0;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 20 && n_cfg == c0; i++) @(negedge clk);
    tests++; if (n_cfg - c0 !== 1 || last_reg !== 8'h03 || last_rw !== 1'b0) begin fails++; $display("FAIL rst_mid_cfg: got cfg=%0d reg=%h rw=%b want 1 03 0", n_cfg - c0, last_reg, last_rw); end
    repeat (100) @(negedge clk);
    tests++; if (n_valid - v0 !== 0 || State !== 8'd0) begin fails++; $display("FAIL rst_mid_dropped: got reads=%0d state=%0d want 0 0", n_valid - v0, State); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_single_read();
    test_periodic();
    test_back_to_back();
    test_nack_retry();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests run", tests);
    $fatal(1);
  end
endmodule

// File: doc/temp_read_scheduler.md
Name: temp_read_scheduler

Overview:
- Sequences temperature-sensor transactions through the bit-level I2C transaction engine:
  - one configuration write after reset or on request;
  - then two-byte temperature reads (MSB register 0x00, LSB register 0x01), triggered by the PC or by a periodic timer.
- Sits between the PC_control endpoint word and the I2C engine.
- Owns retry, timeout and error reporting, and publishes a coherent 16-bit sample to the PC-readable registers.

Parameters:
- DEV_ADDR, 7'h4B, sensor I2C address driven on txn_dev_addr.
- CFG_REG, 8'h03, configuration register address.
- CFG_VALUE, 8'h80, configuration byte written (16-bit resolution).
- PERIOD_CYC, 10000000, clk cycles between periodic reads.
- TIMEOUT_CYC, 200000, maximum clk cycles waiting for txn_done.
- MAX_RETRY, 3, attempts per request before giving up (≥1).

Ports:
- clk  input  1  system clock, derived from sys_clkp/sys_clkn upstream.
- reset  input  1  asynchronous, active-high reset.
- PC_control  input  32  bit0 = single-read trigger (rising edge); bit1 = periodic enable (level); bit2 = reconfigure (rising edge); bit3 = clear error (rising edge); others ignored.
- txn_start  output  1  one-cycle transaction request to the engine.
- txn_rw  output  1  1 = read, 0 = write.
- txn_dev_addr  output  7  device address.
- txn_reg_addr  output  8  register pointer.
- txn_wdata  output  8  write byte.
- txn_busy  input  1  engine busy.
- txn_done  input  1  one-cycle completion pulse.
- txn_ack_err  input  1  NACK flag; valid with txn_done.
- txn_rdata  input  8  read byte; valid with txn_done.
- temp_data  output  16  last good sample {MSB, LSB}.
- temp_valid  output  1  one-cycle pulse when temp_data updates.
- err_sticky  output  1  a request was abandoned after MAX_RETRY failures.
- read_count  output  16  successful reads, wraps 16'hFFFF→0.
- State  output  8  current FSM state code, for debug/LEDs.

Behaviour:
- Reset values (all asynchronous):
  - State = IDLE; txn_start = 0; txn_rw/addr/wdata = 0; temp_data = 0; temp_valid = 0; err_sticky = 0; read_count = 0.
  - Retry and timeout counters = 0; period counter = 0; read_pending = 0; cfg_pending = 1.
  - Edge-detect history regs = 0.
- Reset asserted mid-transaction aborts immediately and drops any pending read; the engine shares the same reset.
- State codes: IDLE=0, CFG_ISSUE=1, CFG_WAIT=2, MSB_ISSUE=3, MSB_WAIT=4, LSB_ISSUE=5, LSB_WAIT=6, UPDATE=7, FAIL=8.
- Triggers:
  - A bit0 rising edge (current=1, registered previous=0) sets read_pending on that clock edge.
  - While bit1=1 the period counter counts 0..PERIOD_CYC-1; at the wrap it sets read_pending. bit1=0 holds the counter at 0.
  - A bit2 edge sets cfg_pending. A bit3 edge clears err_sticky.
  - Requests arriving while busy coalesce into the single pending flag; nothing is queued beyond one.
- IDLE: cfg_pending has priority → CFG_ISSUE; else read_pending → MSB_ISSUE.
- ISSUE states:
  - Wait while txn_busy=1.
  - When txn_busy=0, drive the txn fields, register txn_start=1 for exactly one cycle, and enter the matching WAIT state.
  - Fields per state: CFG is write (CFG_REG, CFG_VALUE); MSB is read (0x00); LSB is read (0x01).
  - Fields stay stable until the next ISSUE.
- WAIT states:
  - The timeout counter clears on entry and increments each cycle.
  - On txn_done with ack_err=0:
    - CFG_WAIT → IDLE and clears cfg_pending.
    - MSB_WAIT latches rdata into the MSB holding reg → LSB_ISSUE.
    - LSB_WAIT latches the LSB → UPDATE.
  - Failure = txn_done with ack_err=1, or timeout counter reaching TIMEOUT_CYC-1 without done.
- Failure handling:
  - retry++.
  - If retry < MAX_RETRY: CFG failure → CFG_ISSUE; MSB or LSB failure → MSB_ISSUE (the pair is always re-read together for coherence).
  - Otherwise → FAIL.
- UPDATE (1 cycle):
  - temp_data ← {MSB, LSB}; temp_valid=1; read_count++; retry=0; read_pending cleared.
  - → IDLE.
- FAIL (1 cycle):
  - err_sticky=1; retry=0; clears the pending flag of the failed request type; previous temp_data is retained.
  - → IDLE.
- Simultaneous events: a bit3 clear and a FAIL in the same cycle → err_sticky=1 (set wins). Trigger edges arriving during UPDATE re-arm read_pending after the clear (set wins).
- Latency: with an idle engine, txn_start appears 2 cycles after the bit0 edge cycle. temp_valid appears 1 cycle after the LSB txn_done.

Test Plan:
- Bench parameters: PERIOD_CYC=1000, TIMEOUT_CYC=50, MAX_RETRY=2; engine model returns done 20 cycles after start.
1. Release reset → CFG write issued first (rw=0, reg 0x03, wdata 0x80), then IDLE, no read without a trigger; State returns to 0.
2. PC_control 0→1, engine returns 0x0C then 0x80 → reads of reg 0x00 then 0x01; temp_data=16'h0C80; one temp_valid pulse; read_count=1.
3. bit1=1 for 3500 cycles → exactly 3 reads; additional bit0 edges during a read coalesce to one extra read.
4. Engine NACKs the LSB once → MSB re-read then LSB; temp_data correct; err_sticky=0.
5. Engine never returns done → two 50-cycle timeouts, FAIL, err_sticky=1, temp_data unchanged; bit3 edge clears it.
6. Assert reset during MSB_WAIT → outputs at reset values within the same cycle; CFG write re-issued after release.
